ads1256_sample_streamer: RTL and testbench
==========================================

ADS1256_SAMPLE_STREAMER -- requirements
Module: ads1256_sample_streamer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter PACKET_LEN, default 16: beats per AXI-Stream packet; >= 1.
REQ-003 SHALL have port clock_i, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset_L_i, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port sample_i, input, 24: conversion word from the SPI stage, two's complement.
REQ-006 SHALL have port sample_valid_i, input, 1: one-cycle pulse qualifying sample_i.
REQ-007 SHALL have port stream_en_i, input, 1: when low, samples are ignored, not counted as drops.
REQ-008 SHALL have port clear_i, input, 1: synchronous flush and statistics clear.
REQ-009 SHALL have port m_axis_tdata_o, output, 32: sign-extended sample.
REQ-010 SHALL have port m_axis_tvalid_o, output, 1: AXI-Stream valid.
REQ-011 SHALL have port m_axis_tready_i, input, 1: AXI-Stream ready.
REQ-012 SHALL have port m_axis_tlast_o, output, 1: last beat of packet.
REQ-013 SHALL have port level_o, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have port overflow_o, output, 1: sticky, set by any dropped sample.
REQ-015 SHALL have port drop_count_o, output, 16: dropped-sample count, saturating.

Function
REQ-016 SHALL push when sample_valid_i && stream_en_i && !clear_i && level < DEPTH, with fullness evaluated at the start of the cycle.
REQ-017 SHALL store {{8{sample_i[23]}}, sample_i}.
REQ-018 SHALL drop a qualifying sample when full at the start of the cycle, even if a pop occurs in that same cycle.
REQ-019 SHALL, on a drop, set overflow_o and increment drop_count_o, holding drop_count_o at 16'hFFFF.
REQ-020 SHALL pop on m_axis_tvalid_o && m_axis_tready_i.
REQ-021 SHALL use first-word fall-through: a sample pushed in cycle N makes tvalid high with that tdata in cycle N+1 when the FIFO was empty.
REQ-022 SHALL, on simultaneous push and pop with 0 < level < DEPTH, leave level unchanged and keep order intact.
REQ-023 SHALL drive m_axis_tvalid_o = (level != 0).
REQ-024 SHALL hold tdata and tlast stable while tvalid && !tready, and SHALL not deassert tvalid before the handshake.
REQ-025 SHALL keep a beat counter 0..PACKET_LEN-1 that increments on each handshake and wraps to 0 after PACKET_LEN-1.
REQ-026 SHALL drive m_axis_tlast_o = tvalid && (beat counter == PACKET_LEN-1); with PACKET_LEN = 1, every beat carries tlast.
REQ-027 SHALL give clear_i priority over push, pop and drop accounting: it empties the FIFO, zeroes the beat counter, and clears overflow_o and drop_count_o.
REQ-028 SHALL allow clear_i to override REQ-024; clear_i is asserted only while the stream is idle or being abandoned.
REQ-029 SHALL wrap the read and write pointers modulo DEPTH, tracking full versus empty with the extra pointer bit.
REQ-030 SHALL gate only future pushes when stream_en_i falls; queued data continues to drain.

Reset
REQ-031 SHALL, while reset_L_i = 0, immediately force: FIFO empty, level_o = 0, m_axis_tvalid_o = 0, m_axis_tlast_o = 0, m_axis_tdata_o = 0, overflow_o = 0, drop_count_o = 0, beat counter = 0.
REQ-032 SHALL, on reset assertion mid-packet or mid-stall, discard all queued data; the first beat after release starts a new packet.
REQ-033 SHALL ignore sample_valid_i in the first cycle after reset release only if it coincides with the deasserting edge; pushes are accepted from the next rising edge onward.

Verification
REQ-034 SHALL cover: tready = 1, push 24'h800001 -> next cycle tvalid = 1 with tdata = 32'hFF800001, level goes 1 then 0 after the handshake.
REQ-035 SHALL cover: DEPTH = 8, tready = 0, 10 pushes -> level_o = 8, overflow_o = 1, drop_count_o = 2; the 8 oldest samples then drain in order.
REQ-036 SHALL cover: PACKET_LEN = 4, 9 samples streamed at tready = 1 -> tlast on beats 4 and 8 only; the counter then stays at 1.
REQ-037 SHALL cover: FIFO full with tready = 1 and a push in the same cycle -> push dropped, drop_count_o + 1, level_o = 7.
REQ-038 SHALL cover: random tready stalls -> tdata and tlast held stable every stalled cycle, with no loss or reorder across 1000 samples.
REQ-039 SHALL cover: clear_i with level = 5 and drop_count = 3 -> next cycle level = 0, tvalid = 0, overflow = 0, drop_count = 0; a same-cycle push is ignored.

Source files
------------

// File: rtl/ads1256_sample_streamer.sv
// Buffers ADS1256 conversion words in a first-word-fall-through FIFO and emits them
// as sign-extended AXI-Stream beats grouped into fixed-length packets, with drop statistics.
module ads1256_sample_streamer #(
  parameter int DEPTH      = 8,
  parameter int PACKET_LEN = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_L_i,
  input  logic [23:0]                sample_i,
  input  logic                       sample_valid_i,
  input  logic                       stream_en_i,
  input  logic                       clear_i,
  output logic [31:0]                m_axis_tdata_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic                       m_axis_tlast_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN - 1);

  function automatic logic [31:0] sign_extend(input logic [23:0] value);
    return {{8{value[23]}}, value};
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [BW-1:0] beat_r;
  logic          overflow_r;
  logic [15:0]   drop_count_r;

  logic [AW:0]   level_s;
  logic          empty_s;
  logic          full_s;
  logic          push_req_s;
  logic          push_s;
  logic          drop_s;
  logic          pop_s;
  logic [31:0]   tdata_s;

  // Occupancy and handshake decisions, all judged on start-of-cycle fullness.
  always_comb begin
    level_s    = wr_ptr_r - rd_ptr_r;
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    push_req_s = sample_valid_i && stream_en_i && !clear_i;
    push_s     = push_req_s && !full_s;
    drop_s     = push_req_s && full_s;
    pop_s      = !empty_s && m_axis_tready_i && !clear_i;
  end

  // Head-of-queue data; forced to zero while empty so reset leaves tdata at zero.
  always_comb begin
    tdata_s = 32'd0;
    if (!empty_s) begin
      tdata_s = mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      tdata_s = 32'd0;
    end
  end

  // Sample storage; contents are meaningless outside the pointer window so no reset.
  always_ff @(posedge clock_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= sign_extend(sample_i);
    end
  end

  // Pointers and packet beat counter; clear flushes ahead of any handshake.
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      beat_r   <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      beat_r   <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        if (beat_r == LAST_BEAT) begin
          beat_r <= '0;
        end else begin
          beat_r <= beat_r + BW'(1);
        end
      end
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (clear_i) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_count_r != 16'hFFFF) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  assign m_axis_tdata_o  = tdata_s;
  assign m_axis_tvalid_o = !empty_s;
  assign m_axis_tlast_o  = !empty_s && (beat_r == LAST_BEAT);
  assign level_o         = level_s;
  assign overflow_o      = overflow_r;
  assign drop_count_o    = drop_count_r;

endmodule

// File: tb/tb_ads1256_sample_streamer.sv
// Randomized and directed checks of ads1256_sample_streamer against a queue-based
// reference model of the buffer, packet counter and drop statistics.
module tb_ads1256_sample_streamer;

  localparam int DEPTH = 8;
  localparam int PL    = 4;

  logic        clock_i = 1'b0;
  logic        reset_L_i = 1'b0;
  logic [23:0] sample_i = 24'd0;
  logic        sample_valid_i = 1'b0;
  logic        stream_en_i = 1'b1;
  logic        clear_i = 1'b0;
  logic [31:0] m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i = 1'b0;
  logic        m_axis_tlast_o;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic [15:0] drop_count_o;

  ads1256_sample_streamer #(.DEPTH(DEPTH), .PACKET_LEN(PL)) dut (
    .clock_i         (clock_i),
    .reset_L_i       (reset_L_i),
    .sample_i        (sample_i),
    .sample_valid_i  (sample_valid_i),
    .stream_en_i     (stream_en_i),
    .clear_i         (clear_i),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tready_i (m_axis_tready_i),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o),
    .drop_count_o    (drop_count_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          m_beats = 0;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  int          m_pushed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_beats = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_outputs();
    bit vld;
    vld = (mq.size() != 0);
    check_eq("tvalid", 32'(m_axis_tvalid_o), 32'(vld));
    check_eq("tdata", m_axis_tdata_o, vld ? mq[0] : 32'd0);
    check_eq("tlast", 32'(m_axis_tlast_o), 32'(vld && (m_beats == PL - 1)));
    check_eq("level", 32'(level_o), 32'(mq.size()));
    check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
    check_eq("drop_count", 32'(drop_count_o), 32'(m_drops));
  endtask

  // Check current outputs, advance the model with the current inputs, then one clock.
  task automatic step();
    bit full, pop, qual;
    check_outputs();
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && m_axis_tready_i && !clear_i;
    qual = sample_valid_i && stream_en_i && !clear_i;
    if (clear_i) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_beats = (m_beats + 1) % PL;
      end
      if (qual) begin
        if (full) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          mq.push_back({{8{sample_i[23]}}, sample_i});
          m_pushed++;
        end
      end
    end
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic push_one(input logic [23:0] s);
    sample_i = s;
    sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_L_i = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge clock_i);
    @(negedge clock_i);
    reset_L_i = 1'b1;
  endtask

  logic [23:0] saved [10];
  int          beat_idx;
  logic [31:0] last_mask;
  int          cycles;

  initial begin
    #1;
    check_outputs();
    @(negedge clock_i);
    reset_L_i = 1'b1;

    // Single sample fall-through with sign extension
    m_axis_tready_i = 1'b1;
    push_one(24'h800001);
    check_eq("fwft_tdata", m_axis_tdata_o, 32'hFF800001);
    check_eq("fwft_level1", 32'(level_o), 32'd1);
    step();
    check_eq("fwft_level0", 32'(level_o), 32'd0);

    // Overfill with stalled sink, then drain in order
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      saved[i] = 24'($urandom());
      push_one(saved[i]);
    end
    check_eq("ovf_level", 32'(level_o), 32'd8);
    check_eq("ovf_flag", 32'(overflow_o), 32'd1);
    check_eq("ovf_drops", 32'(drop_count_o), 32'd2);
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_order", m_axis_tdata_o, {{8{saved[i][23]}}, saved[i]});
      step();
    end

    // Full with a same-cycle pop: push is still dropped
    do_clear();
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 8; i++) push_one(24'($urandom()));
    m_axis_tready_i = 1'b1;
    push_one(24'h123456);
    check_eq("full_pop_drops", 32'(drop_count_o), 32'd1);
    check_eq("full_pop_level", 32'(level_o), 32'd7);
    for (int i = 0; i < 8; i++) step();

    // Packet framing: 9 beats, tlast on beats 4 and 8
    do_clear();
    beat_idx = 0;
    last_mask = 32'd0;
    sample_valid_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sample_i = 24'($urandom());
      if (i == 9) sample_valid_i = 1'b0;
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        beat_idx++;
        if (m_axis_tlast_o) last_mask = last_mask | (32'd1 << beat_idx);
      end
      step();
    end
    check_eq("tlast_beats", last_mask, 32'h0000_0110);
    check_eq("beats_seen", 32'(beat_idx), 32'd9);

    // Clear with level 5 and 3 drops, with a same-cycle push
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 11; i++) push_one(24'($urandom()));
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    m_axis_tready_i = 1'b0;
    check_eq("pre_clear_level", 32'(level_o), 32'd5);
    check_eq("pre_clear_drops", 32'(drop_count_o), 32'd3);
    sample_valid_i = 1'b1;
    sample_i = 24'h0ABCDE;
    do_clear();
    sample_valid_i = 1'b0;
    check_eq("clr_level", 32'(level_o), 32'd0);
    check_eq("clr_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    check_eq("clr_ovf", 32'(overflow_o), 32'd0);
    check_eq("clr_drops", 32'(drop_count_o), 32'd0);

    // Stream disabled: samples ignored, not counted
    m_axis_tready_i = 1'b0;
    stream_en_i = 1'b0;
    for (int i = 0; i < 4; i++) push_one(24'($urandom()));
    check_eq("en_low_level", 32'(level_o), 32'd0);
    stream_en_i = 1'b1;

    // Reset mid-packet and mid-stall, then a fresh packet
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 2; i++) push_one(24'($urandom()));
    step();
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 3; i++) push_one(24'($urandom()));
    do_reset();
    check_eq("rst_level", 32'(level_o), 32'd0);
    check_eq("rst_tdata", m_axis_tdata_o, 32'd0);
    m_axis_tready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_one(24'($urandom()));
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("rst_new_packet_last", 32'(m_axis_tlast_o), 32'd1);
    step();

    // Random traffic with random stalls: 1000 accepted samples
    m_pushed = 0;
    cycles = 0;
    while (m_pushed < 1000 && cycles < 20000) begin
      sample_i        = 24'($urandom());
      sample_valid_i  = ($urandom_range(0, 1) == 1);
      stream_en_i     = ($urandom_range(0, 15) != 0);
      m_axis_tready_i = ($urandom_range(0, 2) != 0);
      step();
      cycles++;
    end
    check_eq("rand_budget", 32'(m_pushed >= 1000), 32'd1);
    sample_valid_i  = 1'b0;
    stream_en_i     = 1'b1;
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    check_eq("rand_drained", 32'(level_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
